// File: rtl/ai_core_pkg.sv
// Shared definitions for the dot-product datapath: width derivations and
// the sequencer FSM state encoding.
package ai_core_pkg;

   // Accumulator width: one full product, 8 bits of lane growth, plus
   // LEN_W bits so a maximum-length job can never overflow.
   function automatic int acc_size(input int in_size_0, input int in_size_1,
                                   input int len_w);
      return in_size_0 + in_size_1 + 8 + len_w;
   endfunction

   // Partial-sum width of the engine: product width plus 8 bits of growth,
   // enough for up to 256 lanes per half.
   function automatic int psum_size(input int in_size_0, input int in_size_1);
      return in_size_0 + in_size_1 + 8;
   endfunction

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } seq_state_e;

endpackage

// File: rtl/baseline.sv
// Combinational signed dot-product engine. Lanes are split into two halves,
// each summed into its own partial-sum output; the consumer adds them.
module baseline
   import ai_core_pkg::*;
#(
   parameter int IN_SIZE_0  = 4,
   parameter int IN_SIZE_1  = 8,
   parameter int SIZE_ARRAY = 8,
   parameter int PS_W       = psum_size(IN_SIZE_0, IN_SIZE_1)
) (
   input  logic [SIZE_ARRAY-1:0][IN_SIZE_0-1:0] in_0_i,
   input  logic [SIZE_ARRAY-1:0][IN_SIZE_1-1:0] in_1_i,
   output logic [1:0][PS_W-1:0]                 out_o
);

   localparam int HALF = SIZE_ARRAY / 2;

   logic [SIZE_ARRAY-1:0][PS_W-1:0] prod;

   // Per-lane signed product, both operands sign-extended to the sum width
   // so the two's-complement sums below are exact.
   for (genvar k = 0; k < SIZE_ARRAY; k++) begin : g_lane
      assign prod[k] = PS_W'($signed(in_0_i[k])) * PS_W'($signed(in_1_i[k]));
   end

   // Lower lanes into out[0], upper lanes (including an odd extra) into out[1].
   always_comb begin
      out_o = '0;
      for (int k = 0; k < SIZE_ARRAY; k++) begin
         if (k < HALF) out_o[0] = out_o[0] + prod[k];
         else          out_o[1] = out_o[1] + prod[k];
      end
   end

endmodule

// File: rtl/dot_product_sequencer.sv
// Streams len beats of lane vectors through the dot-product engine,
// accumulates the per-beat sums and presents the total on a valid/ready
// result port.
module dot_product_sequencer
   import ai_core_pkg::*;
#(
   parameter int IN_SIZE_0  = 4,
   parameter int IN_SIZE_1  = 8,
   parameter int SIZE_ARRAY = 8,
   parameter int LEN_W      = 8,
   localparam int ACC_SIZE  = acc_size(IN_SIZE_0, IN_SIZE_1, LEN_W)
) (
   input  logic                                clk_i,
   input  logic                                rst_ni,
   input  logic                                start_i,
   input  logic [LEN_W-1:0]                    len_i,
   output logic                                busy_o,
   input  logic                                in_valid_i,
   output logic                                in_ready_o,
   input  logic [SIZE_ARRAY-1:0][IN_SIZE_0-1:0] in_0_i,
   input  logic [SIZE_ARRAY-1:0][IN_SIZE_1-1:0] in_1_i,
   output logic                                res_valid_o,
   input  logic                                res_ready_i,
   output logic signed [ACC_SIZE-1:0]          res_o
);

   localparam int PS_W = psum_size(IN_SIZE_0, IN_SIZE_1);

   seq_state_e                 state;
   logic signed [ACC_SIZE-1:0] acc;
   logic signed [ACC_SIZE-1:0] acc_nxt;
   logic signed [ACC_SIZE-1:0] beat_sum;
   logic [LEN_W-1:0]           cnt;
   logic [LEN_W-1:0]           cnt_nxt;
   logic [LEN_W-1:0]           len_q;
   logic [1:0][PS_W-1:0]       psum;
   logic                       beat_fire;

   baseline #(
      .IN_SIZE_0 (IN_SIZE_0),
      .IN_SIZE_1 (IN_SIZE_1),
      .SIZE_ARRAY(SIZE_ARRAY),
      .PS_W      (PS_W)
   ) u_engine (
      .in_0_i(in_0_i),
      .in_1_i(in_1_i),
      .out_o (psum)
   );

   assign beat_fire = in_valid_i && in_ready_o;

   // Next accumulator and beat count for an accepted beat; the two partial
   // sums are sign-extended before adding so the result wraps mod 2^ACC_SIZE.
   always_comb begin
      beat_sum = ACC_SIZE'($signed(psum[0])) + ACC_SIZE'($signed(psum[1]));
      acc_nxt  = acc + beat_sum;
      cnt_nxt  = cnt + 1'b1;
   end

   // Sequencer FSM with registered handshake outputs; res_o is only
   // non-zero while the result is being offered.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state       <= ST_IDLE;
         acc         <= '0;
         cnt         <= '0;
         len_q       <= '0;
         busy_o      <= 1'b0;
         in_ready_o  <= 1'b0;
         res_valid_o <= 1'b0;
         res_o       <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start_i) begin
                  acc    <= '0;
                  cnt    <= '0;
                  busy_o <= 1'b1;
                  if (len_i != '0) begin
                     len_q      <= len_i;
                     in_ready_o <= 1'b1;
                     state      <= ST_RUN;
                  end else begin
                     // Empty job: offer a zero result straight away.
                     res_valid_o <= 1'b1;
                     res_o       <= '0;
                     state       <= ST_DONE;
                  end
               end
            end
            ST_RUN: begin
               if (beat_fire) begin
                  acc <= acc_nxt;
                  cnt <= cnt_nxt;
                  if (cnt_nxt == len_q) begin
                     in_ready_o  <= 1'b0;
                     res_valid_o <= 1'b1;
                     res_o       <= acc_nxt;
                     state       <= ST_DONE;
                  end
               end
            end
            ST_DONE: begin
               if (res_ready_i) begin
                  busy_o      <= 1'b0;
                  res_valid_o <= 1'b0;
                  res_o       <= '0;
                  state       <= ST_IDLE;
               end
            end
            default: begin
               busy_o      <= 1'b0;
               in_ready_o  <= 1'b0;
               res_valid_o <= 1'b0;
               res_o       <= '0;
               state       <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dot_product_sequencer.sv
// Scoreboard bench for dot_product_sequencer: each job's expected sum is
// computed from the driven beats and queued, then popped when the result
// is offered.
module tb_dot_product_sequencer;

   localparam int IN0 = 4;
   localparam int IN1 = 8;
   localparam int SA  = 8;
   localparam int LW  = 8;
   localparam int ACC = IN0 + IN1 + 8 + LW;

   logic                     clk_i = 1'b0;
   logic                     rst_ni;
   logic                     start_i;
   logic [LW-1:0]            len_i;
   logic                     busy_o;
   logic                     in_valid_i;
   logic                     in_ready_o;
   logic [SA-1:0][IN0-1:0]   in_0_i;
   logic [SA-1:0][IN1-1:0]   in_1_i;
   logic                     res_valid_o;
   logic                     res_ready_i;
   logic signed [ACC-1:0]    res_o;

   int     n_chk = 0;
   int     n_err = 0;
   longint sb[$];

   dot_product_sequencer #(
      .IN_SIZE_0 (IN0),
      .IN_SIZE_1 (IN1),
      .SIZE_ARRAY(SA),
      .LEN_W     (LW)
   ) dut (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .start_i    (start_i),
      .len_i      (len_i),
      .busy_o     (busy_o),
      .in_valid_i (in_valid_i),
      .in_ready_o (in_ready_o),
      .in_0_i     (in_0_i),
      .in_1_i     (in_1_i),
      .res_valid_o(res_valid_o),
      .res_ready_i(res_ready_i),
      .res_o      (res_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input longint obs, input longint exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Advance one clock; outputs are then sampled 1 time unit after the edge.
   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_busy"},  busy_o, 0);
      chk({tag, "_rdy"},   in_ready_o, 0);
      chk({tag, "_vld"},   res_valid_o, 0);
      chk({tag, "_res"},   longint'(res_o), 0);
   endtask

   // mode: 0 ones, 1 (-1,127), 2 (-8,-128), other random.
   task automatic run_job(input int len, input int mode, input bit gaps,
                          input int stall, input bit poke);
      int     a[$];
      int     b[$];
      int     av, bv, t;
      longint exp_v, got, hold;
      exp_v = 0;
      for (int i = 0; i < len * SA; i++) begin
         case (mode)
            0:       begin av = 1;  bv = 1;    end
            1:       begin av = -1; bv = 127;  end
            2:       begin av = -8; bv = -128; end
            default: begin
               av = int'($urandom_range(0, 15)) - 8;
               bv = int'($urandom_range(0, 255)) - 128;
            end
         endcase
         a.push_back(av);
         b.push_back(bv);
         exp_v += longint'(av) * longint'(bv);
      end
      sb.push_back(exp_v);

      start_i = 1'b1;
      len_i   = LW'(len);
      step();
      start_i = 1'b0;
      chk("busy", busy_o, 1);

      for (int bt = 0; bt < len; bt++) begin
         if (gaps && (bt % 2 == 1)) begin
            in_valid_i = 1'b0;
            step();
            step();
         end
         for (int k = 0; k < SA; k++) begin
            in_0_i[k] = IN0'(a[bt*SA + k]);
            in_1_i[k] = IN1'(b[bt*SA + k]);
         end
         in_valid_i = 1'b1;
         if (poke && bt == 0) begin
            start_i = 1'b1;
            len_i   = 8'd1;
         end
         t = 0;
         while (!in_ready_o && t < 20) begin
            step();
            t++;
         end
         if (t == 20) chk("rdy_timeout", in_ready_o, 1);
         step();
         start_i    = 1'b0;
         in_valid_i = 1'b0;
         if (bt < len - 1 && res_valid_o) chk("early_vld", res_valid_o, 0);
      end

      // Result must be offered the cycle after the last beat (or the start).
      chk("lat_vld", res_valid_o, 1);
      got  = longint'(res_o);
      hold = sb.pop_front();
      chk("res", got, hold);

      res_ready_i = 1'b0;
      in_valid_i  = 1'b1;
      for (int s = 0; s < stall; s++) begin
         step();
         chk("stall_vld", res_valid_o, 1);
         chk("stall_rdy", in_ready_o, 0);
         chk("stall_res", longint'(res_o), hold);
      end
      in_valid_i = 1'b0;

      // Handshake cycle with start_i held high: must not launch a new job.
      res_ready_i = 1'b1;
      start_i     = 1'b1;
      len_i       = '0;
      step();
      start_i     = 1'b0;
      res_ready_i = 1'b0;
      chk_idle("post");
   endtask

   initial begin
      rst_ni      = 1'b0;
      start_i     = 1'b0;
      len_i       = '0;
      in_valid_i  = 1'b0;
      res_ready_i = 1'b0;
      in_0_i      = '0;
      in_1_i      = '0;
      step();
      step();
      chk_idle("rst");
      rst_ni = 1'b1;
      step();
      chk_idle("rst_rel");

      run_job(1,   0, 1'b0, 0, 1'b0);   // 8
      run_job(3,   1, 1'b0, 0, 1'b0);   // -3048
      run_job(255, 2, 1'b0, 0, 1'b0);   // 2088960
      run_job(4,   3, 1'b1, 5, 1'b0);   // gaps + result backpressure
      run_job(0,   0, 1'b0, 0, 1'b0);   // empty job
      run_job(4,   3, 1'b0, 1, 1'b1);   // start pulsed during RUN

      // Reset arrives with beat 2 of 5 on the bus.
      start_i = 1'b1;
      len_i   = 8'd5;
      step();
      start_i = 1'b0;
      for (int k = 0; k < SA; k++) begin
         in_0_i[k] = 4'd3;
         in_1_i[k] = 8'd5;
      end
      in_valid_i = 1'b1;
      step();
      rst_ni = 1'b0;
      step();
      rst_ni     = 1'b1;
      in_valid_i = 1'b0;
      chk_idle("midrst");
      step();
      chk_idle("midrst2");
      run_job(2, 3, 1'b0, 2, 1'b0);

      chk("sb_empty", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

endmodule

// File: doc/dot_product_sequencer.md
DOT_PRODUCT_SEQUENCER -- requirements
Module: dot_product_sequencer

Interface
REQ-001 SHALL have parameter IN_SIZE_0, default 4, signed lane width of operand 0.
REQ-002 SHALL have parameter IN_SIZE_1, default 8, signed lane width of operand 1.
REQ-003 SHALL have parameter SIZE_ARRAY, default 8, lanes per beat.
REQ-004 SHALL have parameter LEN_W, default 8, width of beat-count field.
REQ-005 SHALL have clk_i  input  1  sole clock, all state on rising edge.
REQ-006 SHALL have rst_ni  input  1  reset, synchronous, active-low.
REQ-007 SHALL have start_i  input  1  begin job, sampled only in IDLE.
REQ-008 SHALL have len_i  input  LEN_W  job length in beats, latched on accepted start.
REQ-009 SHALL have busy_o  output  1  high whenever state is not IDLE.
REQ-010 SHALL have in_valid_i  input  1  operand beat valid.
REQ-011 SHALL have in_ready_o  output  1  operand beat accepted when in_valid_i and in_ready_o are both high.
REQ-012 SHALL have in_0_i  input  SIZE_ARRAY x IN_SIZE_0  operand 0 lanes.
REQ-013 SHALL have in_1_i  input  SIZE_ARRAY x IN_SIZE_1  operand 1 lanes.
REQ-014 SHALL have res_valid_o  output  1  result valid.
REQ-015 SHALL have res_ready_i  input  1  result consumer ready.
REQ-016 SHALL have res_o  output  ACC_SIZE  signed accumulated dot product, ACC_SIZE = IN_SIZE_0+IN_SIZE_1+8+LEN_W.

Function
REQ-017 SHALL implement FSM states IDLE, RUN, DONE.
REQ-018 IDLE: start_i high with len_i != 0 SHALL latch len_i, clear accumulator and beat counter, go to RUN next cycle.
REQ-019 IDLE: start_i high with len_i == 0 SHALL clear accumulator and go directly to DONE (res_o = 0).
REQ-020 in_ready_o SHALL be high only in RUN; no beat is consumed in IDLE or DONE.
REQ-021 Per accepted beat, accumulator SHALL add sign-extended (out[0] + out[1]) of the dot-product engine, i.e. sum over lanes of signed in_0_i[k] * signed in_1_i[k].
REQ-022 Beat counter SHALL increment per accepted beat; on the beat where count reaches latched length, FSM SHALL go to DONE.
REQ-023 res_valid_o SHALL assert the cycle after the last beat is accepted (one-cycle latency), one beat per cycle throughput in RUN.
REQ-024 in_valid_i low cycles in RUN SHALL stall without altering accumulator or counter.
REQ-025 DONE: res_valid_o high, res_o stable until res_valid_o and res_ready_i both high, then IDLE next cycle.
REQ-026 start_i SHALL be ignored in RUN and DONE, including the DONE handshake cycle.
REQ-027 Accumulator SHALL wrap modulo 2^ACC_SIZE; width guarantees no overflow for len_i <= 2^LEN_W-1.
REQ-028 res_o SHALL read 0 outside DONE.

Reset
REQ-029 rst_ni low at a clock edge SHALL force IDLE, accumulator 0, counter 0, from any state including mid-RUN.
REQ-030 During and after reset: busy_o 0, in_ready_o 0, res_valid_o 0, res_o 0.

Structure
REQ-031 ACC_SIZE derivation and FSM state enum SHALL live in shared package ai_core_pkg.
REQ-032 The combinational dot-product engine SHALL be instantiated as sub-module baseline (two partial-sum outputs), not re-implemented.

Verification
REQ-033 len=1, all lanes in_0=1, in_1=1 -> res_o=8, res_valid_o high one cycle after the beat.
REQ-034 len=3, all lanes in_0=-1, in_1=127 -> res_o=-3048.
REQ-035 len=255, all lanes in_0=-8, in_1=-128, back-to-back beats -> res_o=2088960, no overflow.
REQ-036 len=4 with in_valid_i gaps and res_ready_i low 5 cycles -> same result as gap-free run, res_o stable, in_ready_o 0 throughout DONE.
REQ-037 len=0 -> res_valid_o with res_o=0 next cycle; start_i pulsed during RUN -> ignored, job result unchanged.
REQ-038 rst_ni low for 1 cycle mid-RUN (beat 2 of 5) -> all outputs 0, IDLE; fresh len=2 job then returns correct sum.
